mio_bus_resp: RTL

MIO_BUS_RESP -- requirements
Module: mio_bus_resp

---
 rtl/mio_bus_resp.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mio_bus_resp.sv
// CPU memory/IO bus responder: decodes RAM, peripheral and out-of-range accesses with fixed wait states.
// Optional macro MIO_WRMASK_EN: honour byte enables on writes (RAM merge, io_we only for be != 0).
module mio_bus_resp #(
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned RAM_WAIT = 2,
  parameter int unsigned IO_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_w,
  input  logic [31:0] M_addr,
  input  logic [31:0] data_out,
  input  logic [3:0]  be,
  output logic [31:0] data2CPU,
  output logic        MIO_ready,
  output logic        err,
  output logic        io_cs,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);

  localparam int unsigned DW        = 32;
  localparam int unsigned CW        = 4;
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {K_RAM, K_IO, K_OOR} kind_e;

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [RAM_AW-1:0]   idx_q, idx_d;
  logic [7:0]          ioa_q, ioa_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                io_cs_q, io_cs_d;
  logic                io_we_q, io_we_d;
  logic                ram_we_c;
  logic [DW-1:0]       ram_wdata_c;
  logic [DW-1:0]       ram_q [RAM_WORDS];
`ifdef MIO_WRMASK_EN
  logic [3:0]          be_q, be_d;
  logic                unused_c;
  assign unused_c = ^M_addr[1:0];
`else
  logic                unused_c;
  assign unused_c = ^{M_addr[1:0], be};
`endif

  // Next-state, request capture and access execution
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    ioa_d    = ioa_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    io_cs_d  = 1'b0;
    ram_we_c = 1'b0;
`ifdef MIO_WRMASK_EN
    be_d     = be_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          wr_d    = mem_w;
          idx_d   = M_addr[RAM_AW+1:2];
          ioa_d   = M_addr[9:2];
          wdata_d = data_out;
`ifdef MIO_WRMASK_EN
          be_d    = be;
`endif
          if (M_addr[31:28] == 4'hF)            kind_d = K_IO;
          else if (M_addr[31:RAM_AW+2] == '0)   kind_d = K_RAM;
          else                                  kind_d = K_OOR;
          cnt_d   = (kind_d == K_IO) ? CW'(IO_WAIT) : CW'(RAM_WAIT);
          state_d = S_WAIT;
          io_cs_d = (kind_d == K_IO) && (cnt_d == '0);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          err_d   = (kind_q == K_OOR);
          if (wr_q) begin
            ram_we_c = (kind_q == K_RAM);
          end else begin
            case (kind_q)
              K_RAM:   rdata_d = ram_q[idx_q];
              K_IO:    rdata_d = io_rdata;
              default: rdata_d = '0;
            endcase
          end
        end else begin
          cnt_d   = cnt_q - CW'(1);
          io_cs_d = (kind_q == K_IO) && (cnt_d == '0);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef MIO_WRMASK_EN
    io_we_d = io_cs_d && wr_d && (be_d != 4'h0);
`else
    io_we_d = io_cs_d && wr_d;
`endif
  end

  // Write data merge for RAM stores
  always_comb begin
`ifdef MIO_WRMASK_EN
    ram_wdata_c = ram_q[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) ram_wdata_c[8*i +: 8] = wdata_q[8*i +: 8];
    end
`else
    ram_wdata_c = wdata_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_RAM;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      ioa_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      io_cs_q <= 1'b0;
      io_we_q <= 1'b0;
`ifdef MIO_WRMASK_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      ioa_q   <= ioa_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      io_cs_q <= io_cs_d;
      io_we_q <= io_we_d;
`ifdef MIO_WRMASK_EN
      be_q    <= be_d;
`endif
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_c) ram_q[idx_q] <= ram_wdata_c;
  end

  assign data2CPU  = rdata_q;
  assign MIO_ready = ready_q;
  assign err       = err_q;
  assign io_cs     = io_cs_q;
  assign io_we     = io_we_q;
  assign io_addr   = ioa_q;
  assign io_wdata  = wdata_q;

endmodule
